// File: rtl/uart_rx.sv
// 8N1 UART receiver. The serial line is double-flopped into the clock domain, the
// start bit is confirmed at mid-bit, and each data/stop bit is then sampled one full
// bit period later, i.e. at its own mid-bit. A good stop bit produces a one-cycle
// o_Rx_DV strobe with the byte; a low stop bit produces a one-cycle o_Rx_Frame_Err
// strobe, after which the receiver waits for the line to return high before
// re-arming, so a held break yields a single error.
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 174
) (
    input  logic       clock,
    input  logic       rst,
    input  logic       i_Rx_Serial,
    output logic       o_Rx_DV,
    output logic [7:0] o_Rx_Byte,
    output logic       o_Rx_Frame_Err,
    output logic       o_Rx_Busy
);

    // Mid-bit offset used to confirm the start bit.
    localparam int unsigned HALF_BIT = (CLKS_PER_BIT - 1) / 2;

    // Counter compare values; the counter is 8 bits, so CLKS_PER_BIT must stay <= 255.
    localparam logic [7:0] LastCnt = 8'(CLKS_PER_BIT - 1);
    localparam logic [7:0] HalfCnt = 8'(HALF_BIT);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StCleanup,
        StWaitHigh
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] byte_q, byte_d;
    logic       dv_q, dv_d;
    logic       err_q, err_d;
    logic       sync1_q, sync1_d;
    logic       rx_s_q, rx_s_d;
    logic       rx_s;

    // Two-flop synchronizer inputs; everything downstream uses rx_s only.
    always_comb begin
        sync1_d = i_Rx_Serial;
        rx_s_d  = sync1_q;
    end

    assign rx_s = rx_s_q;

    // Synchronizer flops; they reset to the idle (high) line level so that leaving
    // reset never looks like a start edge.
    always_ff @(posedge clock) begin
        if (!rst) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
        end else begin
            sync1_q <= sync1_d;
            rx_s_q  <= rx_s_d;
        end
    end

    // Receive FSM: next state, bit-period counter, bit index, shift register and strobes.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        byte_d  = byte_q;
        dv_d    = 1'b0;
        err_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                cnt_d = 8'd0;
                idx_d = 3'd0;
                if (!rx_s) begin
                    state_d = StStart;
                end
            end

            StStart: begin
                if (cnt_q == HalfCnt) begin
                    cnt_d = 8'd0;
                    // Still low at mid-bit: a real start bit. High again: a glitch.
                    state_d = rx_s ? StIdle : StData;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            StData: begin
                if (cnt_q == LastCnt) begin
                    cnt_d          = 8'd0;
                    shift_d[idx_q] = rx_s;
                    if (idx_q == 3'd7) begin
                        idx_d   = 3'd0;
                        state_d = StStop;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            StStop: begin
                if (cnt_q == LastCnt) begin
                    cnt_d = 8'd0;
                    if (rx_s) begin
                        byte_d = shift_q;
                        dv_d   = 1'b1;
                    end else begin
                        // Framing error: the previously delivered byte is kept.
                        err_d = 1'b1;
                    end
                    state_d = StCleanup;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            StCleanup: begin
                // err_q is high exactly in this cycle when the stop bit was bad.
                state_d = err_q ? StWaitHigh : StIdle;
            end

            StWaitHigh: begin
                if (rx_s) begin
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!rst) begin
            state_q <= StIdle;
            cnt_q   <= 8'd0;
            idx_q   <= 3'd0;
            shift_q <= 8'd0;
            byte_q  <= 8'd0;
            dv_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            byte_q  <= byte_d;
            dv_q    <= dv_d;
            err_q   <= err_d;
        end
    end

    assign o_Rx_DV        = dv_q;
    assign o_Rx_Byte      = byte_q;
    assign o_Rx_Frame_Err = err_q;
    assign o_Rx_Busy      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: one instance at 16 clocks/bit and one at the default 174.
// Stimulus pushes the expected strobe (kind, byte, cycle) into a per-instance queue;
// a negedge monitor pops and compares whenever a strobe appears.
module tb_uart_rx;

    localparam int C16  = 16;
    localparam int H16  = 7;
    localparam int C174 = 174;
    localparam int H174 = 86;

    logic       clock = 1'b0;
    logic       rst;
    logic       rx16, rx174;
    logic       dv16, err16, busy16;
    logic [7:0] byte16;
    logic       dv174, err174, busy174;
    logic [7:0] byte174;

    int cyc     = 0;
    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        bit         err;
        logic [7:0] data;
        int         at;
    } ev_t;

    ev_t q16[$];
    ev_t q174[$];

    uart_rx #(.CLKS_PER_BIT(C16)) dut16 (
        .clock          (clock),
        .rst            (rst),
        .i_Rx_Serial    (rx16),
        .o_Rx_DV        (dv16),
        .o_Rx_Byte      (byte16),
        .o_Rx_Frame_Err (err16),
        .o_Rx_Busy      (busy16)
    );

    uart_rx dut174 (
        .clock          (clock),
        .rst            (rst),
        .i_Rx_Serial    (rx174),
        .o_Rx_DV        (dv174),
        .o_Rx_Byte      (byte174),
        .o_Rx_Frame_Err (err174),
        .o_Rx_Busy      (busy174)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard side: compare one instance's strobes against its expectation queue.
    task automatic mon(input int which, input logic dv, input logic err, input logic [7:0] b);
        ev_t ev;
        bit  have;
        if (dv === 1'b1 && err === 1'b1) begin
            n_tests++;
            n_fail++;
            $display("FAIL sb%0d exclusive: DV and Frame_Err both high at cycle %0d", which, cyc);
        end else if (dv === 1'b1 || err === 1'b1) begin
            n_tests++;
            have = (which == 0) ? (q16.size() > 0) : (q174.size() > 0);
            if (!have) begin
                n_fail++;
                $display("FAIL sb%0d unexpected strobe: dv=%0b err=%0b byte=%02h at cycle %0d",
                         which, dv, err, b, cyc);
            end else begin
                ev = (which == 0) ? q16.pop_front() : q174.pop_front();
                if (ev.err !== err || ev.data !== b || ev.at != cyc) begin
                    n_fail++;
                    $display("FAIL sb%0d strobe: got err=%0b byte=%02h at cycle %0d, expected err=%0b byte=%02h at cycle %0d",
                             which, err, b, cyc, ev.err, ev.data, ev.at);
                end
            end
        end
    endtask

    always @(negedge clock) begin
        if (rst === 1'b1) begin
            mon(0, dv16, err16, byte16);
            mon(1, dv174, err174, byte174);
        end
    end

    task automatic set_line(input int which, input logic v);
        if (which == 0) rx16 = v;
        else            rx174 = v;
    endtask

    task automatic hold(input int which, input logic v, input int n);
        set_line(which, v);
        repeat (n) @(negedge clock);
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clock);
    endtask

    // Send one 8N1 frame; called on a negedge, so cyc is the cycle the start edge is driven.
    task automatic send_frame(input int which, input logic [7:0] d, input logic stop,
                              input logic [7:0] prev_byte);
        int  c;
        int  h;
        ev_t ev;
        c       = (which == 0) ? C16 : C174;
        h       = (which == 0) ? H16 : H174;
        ev.err  = !stop;
        ev.data = stop ? d : prev_byte;
        // 2 sync cycles to t0, then the strobe at t0+2+HALF_BIT+9*CLKS_PER_BIT.
        ev.at   = cyc + 4 + h + 9 * c;
        if (which == 0) q16.push_back(ev);
        else            q174.push_back(ev);
        hold(which, 1'b0, c);
        for (int i = 0; i < 8; i++) hold(which, d[i], c);
        hold(which, stop, c);
    endtask

    // 174-clock frame with per-bit period jitter; cumulative drift stays within 8 cycles.
    task automatic send_jitter(input logic [7:0] d);
        int  jit[10];
        ev_t ev;
        jit     = '{8, -8, 5, -5, 8, -8, 3, -3, 8, 0};
        ev.err  = 1'b0;
        ev.data = d;
        ev.at   = cyc + 4 + H174 + 9 * C174;
        q174.push_back(ev);
        hold(1, 1'b0, C174 + jit[0]);
        for (int i = 0; i < 8; i++) hold(1, d[i], C174 + jit[i+1]);
        hold(1, 1'b1, C174 + jit[9]);
    endtask

    task automatic check_idle16(input string name, input logic [7:0] exp_byte);
        check({name, " dv"},   {31'd0, dv16},   32'd0);
        check({name, " err"},  {31'd0, err16},  32'd0);
        check({name, " busy"}, {31'd0, busy16}, 32'd0);
        check({name, " byte"}, {24'd0, byte16}, {24'd0, exp_byte});
    endtask

    initial begin
        int f;
        int m;

        rst   = 1'b0;
        rx16  = 1'b1;
        rx174 = 1'b1;
        repeat (3) @(negedge clock);
        check_idle16("reset16", 8'h00);
        check("reset174 busy", {31'd0, busy174}, 32'd0);
        check("reset174 byte", {24'd0, byte174}, 32'd0);
        rst = 1'b1;
        repeat (5) @(negedge clock);
        check_idle16("post-reset16", 8'h00);

        // 1: 0xA5, DV at fall+155, Busy over fall+3..fall+155.
        f = cyc;
        fork
            send_frame(0, 8'hA5, 1'b1, 8'h00);
            begin
                wait_until(f + 2);   check("t1 busy before", {31'd0, busy16}, 32'd0);
                wait_until(f + 3);   check("t1 busy rise",   {31'd0, busy16}, 32'd1);
                wait_until(f + 155); check("t1 busy at dv",  {31'd0, busy16}, 32'd1);
                wait_until(f + 156); check("t1 busy after",  {31'd0, busy16}, 32'd0);
            end
        join
        hold(0, 1'b1, 10);
        check_idle16("t1 end", 8'hA5);

        // 2: 5-cycle glitch rejected at mid start bit.
        f = cyc;
        fork
            begin
                hold(0, 1'b0, 5);
                hold(0, 1'b1, 30);
            end
            begin
                wait_until(f + 10); check("t2 busy at check", {31'd0, busy16}, 32'd1);
                wait_until(f + 11); check("t2 busy idle",     {31'd0, busy16}, 32'd0);
            end
        join
        check_idle16("t2 end", 8'hA5);

        // 3: bad stop bit, break held, then recovery with 0x81.
        send_frame(0, 8'h3C, 1'b0, 8'hA5);
        hold(0, 1'b0, 100);
        check("t3 busy in break", {31'd0, busy16}, 32'd1);
        check("t3 byte kept",     {24'd0, byte16}, 32'h0000_00A5);
        m = cyc;
        set_line(0, 1'b1);
        wait_until(m + 2); check("t3 busy before rise seen", {31'd0, busy16}, 32'd1);
        wait_until(m + 3); check("t3 busy released",         {31'd0, busy16}, 32'd0);
        hold(0, 1'b1, 30);
        check_idle16("t3 no phantom", 8'hA5);
        send_frame(0, 8'h81, 1'b1, 8'hA5);
        hold(0, 1'b1, 10);
        check("t3 recovered byte", {24'd0, byte16}, 32'h0000_0081);

        // 4: back-to-back frames, expected strobes 160 cycles apart.
        send_frame(0, 8'h00, 1'b1, 8'h81);
        send_frame(0, 8'hFF, 1'b1, 8'h00);
        send_frame(0, 8'h55, 1'b1, 8'hFF);
        hold(0, 1'b1, 10);
        check("t4 last byte", {24'd0, byte16}, 32'h0000_0055);

        // 5: reset during data bit 4 of 0x96, then a clean 0x96.
        hold(0, 1'b0, C16);
        for (int i = 0; i < 4; i++) hold(0, 1'(8'h96 >> i), C16);
        hold(0, 1'b1, C16 / 2);
        check("t5 busy before reset", {31'd0, busy16}, 32'd1);
        rst = 1'b0;
        @(negedge clock);
        check_idle16("t5 in reset", 8'h00);
        hold(0, 1'b1, 3);
        rst = 1'b1;
        hold(0, 1'b1, 20);
        check_idle16("t5 after reset", 8'h00);
        send_frame(0, 8'h96, 1'b1, 8'h00);
        hold(0, 1'b1, 10);
        check("t5 byte", {24'd0, byte16}, 32'h0000_0096);

        // 6: default rate with jitter.
        send_jitter(8'h5A);
        hold(1, 1'b1, 20);
        check("t6 byte", {24'd0, byte174}, 32'h0000_005A);
        check("t6 busy", {31'd0, busy174}, 32'd0);

        repeat (50) @(negedge clock);
        check("sb16 pending",  q16.size(),  32'd0);
        check("sb174 pending", q174.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
